// File: rtl/clk_skew_pkg.sv
// Shared helpers for the programmable skew delay line.
// Provides the latency-field width helper and the latency clamp function.
// No ports; imported by clk_skew_line and skew_line_chan.
package clk_skew_pkg;

    // Width of a latency field able to hold 0..max_dly.
    function automatic int unsigned dly_width(input int unsigned max_dly);
        return $clog2(max_dly + 1);
    endfunction

    // Force a requested latency into the legal range 1..max_dly.
    function automatic int unsigned clamp_dly(input int unsigned value, input int unsigned max_dly);
        if (value == 0) begin
            return 1;
        end
        if (value > max_dly) begin
            return max_dly;
        end
        return value;
    endfunction

endpackage

// File: rtl/skew_line_chan.sv
// One lane of the skew line: delays a valid-qualified sample by cur_dly cycles (1..MAX_DLY).
// Latency cur_dly cycles, output always registered; never stalls, no backpressure.
// Ports: clk/rst, flush (drop in-flight samples), cur_dly (latency for this edge), in_valid/in_data, out_valid/out_data.
module skew_line_chan
    import clk_skew_pkg::*;
#(
    parameter  int WIDTH     = 1,
    parameter  int MAX_DLY   = 4,
    parameter  int HOLD_MODE = 1,
    localparam int DW        = dly_width(MAX_DLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DW-1:0]    cur_dly,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // The output register is the last stage, so only MAX_DLY-1 shift stages
    // sit in front of it. A degenerate MAX_DLY of 1 keeps one unused stage.
    localparam int NST = (MAX_DLY > 1) ? MAX_DLY - 1 : 1;

    logic             st_vld_q [NST];
    logic [WIDTH-1:0] st_dat_q [NST];

    logic             tap_vld;
    logic [WIDTH-1:0] tap_dat;
    logic             out_vld_d, out_vld_q;
    logic [WIDTH-1:0] out_dat_d, out_dat_q;

    // Stage j holds a sample j+1 edges old, so latency d taps stage d-2;
    // latency 1 taps the input directly into the output register.
    always_comb begin
        tap_vld = in_valid;
        tap_dat = in_data;
        for (int j = 0; j < NST; j++) begin
            if (cur_dly == DW'(j + 2)) begin
                tap_vld = st_vld_q[j];
                tap_dat = st_dat_q[j];
            end
        end
        // A flush discards everything already in the stages; only a sample
        // presented on the flush edge under a new latency of 1 may pass.
        if (flush && (cur_dly != DW'(1))) begin
            tap_vld = 1'b0;
        end

        out_vld_d = tap_vld;
        if (tap_vld) begin
            out_dat_d = tap_dat;
        end else if (HOLD_MODE != 0) begin
            out_dat_d = out_dat_q;
        end else begin
            out_dat_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NST; j++) begin
                st_vld_q[j] <= 1'b0;
                st_dat_q[j] <= '0;
            end
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            // First stage always accepts the current sample, even on a flush.
            st_vld_q[0] <= in_valid;
            if (in_valid) begin
                st_dat_q[0] <= in_data;
            end
            // Data only moves with a valid; bubbles leave stage data untouched.
            for (int j = 1; j < NST; j++) begin
                st_vld_q[j] <= flush ? 1'b0 : st_vld_q[j-1];
                if (st_vld_q[j-1]) begin
                    st_dat_q[j] <= st_dat_q[j-1];
                end
            end
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;

endmodule

// File: rtl/clk_skew_line.sv
// Multi-lane programmable skew line: CHANNELS independent WIDTH-bit lanes with shared latency 1..MAX_DLY.
// Latency cur_dly cycles, registered outputs; lanes never stall, a latency load flushes all lanes.
// Ports: clk/rst, in_valid/in_data, dly_load/dly_val (latency program), out_valid/out_data, cur_dly, busy (refill in progress).
module clk_skew_line
    import clk_skew_pkg::*;
#(
    parameter  int WIDTH     = 1,
    parameter  int CHANNELS  = 2,
    parameter  int MAX_DLY   = 4,
    parameter  int HOLD_MODE = 1,
    localparam int DW        = dly_width(MAX_DLY)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      dly_load,
    input  logic [DW-1:0]             dly_val,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [DW-1:0]             cur_dly,
    output logic                      busy
);

    logic [DW-1:0] dly_new;
    logic [DW-1:0] dly_eff;
    logic [DW-1:0] cur_dly_d, cur_dly_q;
    logic [DW-1:0] busy_cnt_d, busy_cnt_q;

    always_comb begin
        dly_new = DW'(clamp_dly(32'(dly_val), MAX_DLY));
        // Samples on the load edge already travel under the new latency.
        dly_eff = dly_load ? dly_new : cur_dly_q;

        cur_dly_d  = cur_dly_q;
        busy_cnt_d = busy_cnt_q;
        if (dly_load) begin
            // New data first emerges d-1 edges after the load edge; a reload
            // restarts the count against the latest latency.
            cur_dly_d  = dly_new;
            busy_cnt_d = dly_new - DW'(1);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_dly_q  <= DW'(1);
            busy_cnt_q <= '0;
        end else begin
            cur_dly_q  <= cur_dly_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign cur_dly = cur_dly_q;
    assign busy    = (busy_cnt_q != '0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        skew_line_chan #(
            .WIDTH     (WIDTH),
            .MAX_DLY   (MAX_DLY),
            .HOLD_MODE (HOLD_MODE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .flush     (dly_load),
            .cur_dly   (dly_eff),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_clk_skew_line.sv
// Directed bench for clk_skew_line: one hold-mode and one zero-mode instance on shared stimulus.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Checks reset, latency 1/3/4, clamping, busy length, flush, bubbles and mid-stream async reset.
module tb_clk_skew_line;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int MD = 4;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH*W-1:0] in_data = '0;
    logic            dly_load = 1'b0;
    logic [DW-1:0]   dly_val = '0;

    logic [CH-1:0]   h_vld, z_vld;
    logic [CH*W-1:0] h_dat, z_dat;
    logic [DW-1:0]   h_dly, z_dly;
    logic            h_busy, z_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_skew_line #(.WIDTH(W), .CHANNELS(CH), .MAX_DLY(MD), .HOLD_MODE(1)) u_hold (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .dly_load(dly_load), .dly_val(dly_val),
        .out_valid(h_vld), .out_data(h_dat), .cur_dly(h_dly), .busy(h_busy)
    );

    clk_skew_line #(.WIDTH(W), .CHANNELS(CH), .MAX_DLY(MD), .HOLD_MODE(0)) u_zero (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .dly_load(dly_load), .dly_val(dly_val),
        .out_valid(z_vld), .out_data(z_dat), .cur_dly(z_dly), .busy(z_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset (async, before any clock edge)
        #1 rst = 1'b1;
        #1;
        chk("rst_vld", 16'(h_vld), 16'h0);
        chk("rst_dat", h_dat, 16'h0);
        chk("rst_dly", 16'(h_dly), 16'h1);
        chk("rst_busy", 16'(h_busy), 16'h0);
        step();
        #4 rst = 1'b0;
        #1;

        // ---------------- latency 1, lane0 0,1,1
        in_valid = 2'b01; in_data[7:0] = 8'h00; step();
        chk("d1_vld0", 16'(h_vld), 16'h1);
        chk("d1_dat0", 16'(h_dat[7:0]), 16'h00);
        in_data[7:0] = 8'h01; step();
        chk("d1_dat1", 16'(h_dat[7:0]), 16'h01);
        in_data[7:0] = 8'h01; step();
        chk("d1_dat2", 16'(h_dat[7:0]), 16'h01);
        chk("d1_dly", 16'(h_dly), 16'h1);
        chk("d1_busy", 16'(h_busy), 16'h0);
        in_valid = 2'b00; step();
        chk("d1_idle_vld", 16'(h_vld), 16'h0);
        chk("d1_hold_dat", 16'(h_dat[7:0]), 16'h01);
        chk("d1_zero_dat", 16'(z_dat[7:0]), 16'h00);

        // ---------------- load latency 3, lane1 A5 then 3C
        dly_load = 1'b1; dly_val = 3'd3; step();
        dly_load = 1'b0;
        chk("d3_dly", 16'(h_dly), 16'h3);
        chk("d3_busy_a", 16'(h_busy), 16'h1);
        in_valid = 2'b10; in_data[15:8] = 8'hA5; step();
        chk("d3_busy_b", 16'(h_busy), 16'h1);
        chk("d3_early_a", 16'(h_vld), 16'h0);
        in_data[15:8] = 8'h3C; step();
        chk("d3_busy_c", 16'(h_busy), 16'h0);
        chk("d3_early_b", 16'(h_vld), 16'h0);
        in_valid = 2'b00; step();
        chk("d3_vld_a5", 16'(h_vld), 16'h2);
        chk("d3_dat_a5", 16'(h_dat[15:8]), 16'hA5);
        step();
        chk("d3_vld_3c", 16'(h_vld), 16'h2);
        chk("d3_dat_3c", 16'(h_dat[15:8]), 16'h3C);
        step();
        chk("d3_end_vld", 16'(h_vld), 16'h0);
        chk("d3_hold_dat", 16'(h_dat[15:8]), 16'h3C);
        chk("d3_zero_dat", 16'(z_dat[15:8]), 16'h00);

        // ---------------- clamping
        dly_load = 1'b1; dly_val = 3'd0; step();
        chk("clamp0_dly", 16'(h_dly), 16'h1);
        chk("clamp0_busy", 16'(h_busy), 16'h0);
        dly_val = 3'd7; step();
        dly_load = 1'b0;
        chk("clamp7_dly", 16'(h_dly), 16'h4);
        chk("clamp7_busy", 16'(h_busy), 16'h1);

        // ---------------- flush at latency 4
        in_valid = 2'b01; in_data[7:0] = 8'h11; step();
        in_data[7:0] = 8'h22; step();
        dly_load = 1'b1; dly_val = 3'd4; in_data[7:0] = 8'h33; step();
        dly_load = 1'b0; in_valid = 2'b00;
        chk("fl_busy", 16'(h_busy), 16'h1);
        chk("fl_vld0", 16'(h_vld), 16'h0);
        step();
        chk("fl_vld1", 16'(h_vld), 16'h0);
        step();
        chk("fl_vld2", 16'(h_vld), 16'h0);
        step();
        chk("fl_vld3", 16'(h_vld), 16'h1);
        chk("fl_dat3", 16'(h_dat[7:0]), 16'h33);
        chk("fl_busy3", 16'(h_busy), 16'h0);
        step();
        chk("fl_vld4", 16'(h_vld), 16'h0);

        // ---------------- bubbles at latency 4: 5, bubble, 9
        in_valid = 2'b01; in_data[7:0] = 8'h05; step();
        in_valid = 2'b00; in_data[7:0] = 8'hFF; step();
        in_valid = 2'b01; in_data[7:0] = 8'h09; step();
        in_valid = 2'b00; step();
        chk("bb_vld5", 16'(h_vld), 16'h1);
        chk("bb_dat5", 16'(h_dat[7:0]), 16'h05);
        chk("bb_zdat5", 16'(z_dat[7:0]), 16'h05);
        step();
        chk("bb_vld_bub", 16'(h_vld), 16'h0);
        chk("bb_hold_bub", 16'(h_dat[7:0]), 16'h05);
        chk("bb_zero_bub", 16'(z_dat[7:0]), 16'h00);
        step();
        chk("bb_vld9", 16'(h_vld), 16'h1);
        chk("bb_dat9", 16'(h_dat[7:0]), 16'h09);
        chk("bb_zdat9", 16'(z_dat[7:0]), 16'h09);

        // ---------------- async reset mid-stream at latency 3
        dly_load = 1'b1; dly_val = 3'd3; step();
        dly_load = 1'b0;
        in_valid = 2'b01; in_data[7:0] = 8'h77; step();
        in_valid = 2'b00; step();
        step();
        chk("ar_pre_vld", 16'(h_vld), 16'h1);
        chk("ar_pre_dat", 16'(h_dat[7:0]), 16'h77);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", 16'(h_vld), 16'h0);
        chk("ar_dat", h_dat, 16'h0);
        chk("ar_dly", 16'(h_dly), 16'h1);
        chk("ar_busy", 16'(h_busy), 16'h0);
        #1 rst = 1'b0;
        in_valid = 2'b10; in_data[15:8] = 8'h42; step();
        in_valid = 2'b00;
        chk("ar_first_vld", 16'(h_vld), 16'h2);
        chk("ar_first_dat", 16'(h_dat[15:8]), 16'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
